// File: rtl/clv_canon.sv
// Canonical Huffman code generator: loads per-symbol code lengths, builds the
// RFC 1951 next_code table, checks the Kraft sum and streams {sym, len, code}.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   len_valid/len_in     : length stream in, symbol order 0..NUM_SYMBOLS-1
//   len_ready            : block accepts lengths (IDLE/LOAD)
//   code_valid/code_ready: output triple handshake
//   code_sym/len/out     : symbol index, its length, right-justified code
//   done                 : one-cycle pulse at end of a run
//   error/incomplete     : over-subscribed / Kraft sum < 1, held until next load
module clv_canon #(
  parameter int NUM_SYMBOLS = 288,
  parameter int MAX_LEN     = 15,
  parameter int LEN_W       = 4,
  parameter int SYM_W       = 9,
  parameter bit REVERSE     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               len_valid,
  input  logic [LEN_W-1:0]   len_in,
  output logic               len_ready,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [SYM_W-1:0]   code_sym,
  output logic [LEN_W-1:0]   code_len,
  output logic [MAX_LEN-1:0] code_out,
  output logic               done,
  output logic               error,
  output logic               incomplete
);

  localparam int CW = MAX_LEN + 1;
  localparam int LW = MAX_LEN + 2;
  localparam int BW = SYM_W + 1;
  localparam int NL = 1 << LEN_W;
  localparam logic [SYM_W-1:0] LAST = SYM_W'(NUM_SYMBOLS - 1);
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_EMIT,
    S_FIN
  } state_t;

  state_t                   state_q;
  logic [SYM_W-1:0]         idx_q;
  logic [LEN_W-1:0]         step_q;
  logic [MAX_LEN-1:0]       code_q;
  logic signed [LW-1:0]     left_q;
  logic [LEN_W-1:0]         len_q [NUM_SYMBOLS];
  logic [BW-1:0]            bl_q  [NL];
  logic [MAX_LEN-1:0]       nc_q  [NL];

  logic                     code_valid_q;
  logic [SYM_W-1:0]         code_sym_q;
  logic [LEN_W-1:0]         code_len_q;
  logic [MAX_LEN-1:0]       code_out_q;
  logic                     done_q;
  logic                     error_q;
  logic                     incomplete_q;

  logic                     accept;
  logic [LEN_W-1:0]         prev;
  logic [CW-1:0]            csum;
  logic [CW-1:0]            cshl;
  logic [MAX_LEN-1:0]       code_d;
  logic signed [LW-1:0]     left_d;
  logic                     neg_d;
  logic [LEN_W-1:0]         elen;
  logic [MAX_LEN-1:0]       eraw;
  logic [MAX_LEN-1:0]       erev_full;
  logic [MAX_LEN-1:0]       erev;
  logic [MAX_LEN-1:0]       ecode_d;
  logic                     hs;
  logic                     last_hs;
  logic                     load;

  assign len_ready  = !reset &&
                      (state_q == S_IDLE || state_q == S_LOAD);
  assign code_valid = code_valid_q;
  assign code_sym   = code_sym_q;
  assign code_len   = code_len_q;
  assign code_out   = code_out_q;
  assign done       = done_q;
  assign error      = error_q;
  assign incomplete = incomplete_q;

  always_comb begin
    accept = len_valid & len_ready;
    // bl_q[0] is never incremented, so step 1 adds zero.
    prev   = step_q - LEN_W'(1);
    csum   = {1'b0, code_q} + CW'(bl_q[prev]);
    cshl   = csum << 1;
    code_d = cshl[MAX_LEN-1:0];
    left_d = (left_q <<< 1) - $signed(LW'(bl_q[step_q]));
    neg_d  = left_d < 0;
    elen   = len_q[idx_q];
    eraw   = nc_q[elen];
    erev_full = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      erev_full[i] = eraw[MAX_LEN-1-i];
    end
    // Full-width reversal, then drop the bits below the code length.
    erev    = erev_full >> (MAXL - elen);
    ecode_d = '0;
    if (elen != '0) begin
      ecode_d = REVERSE ? erev : eraw;
    end
    hs      = code_valid_q & code_ready;
    last_hs = hs && (code_sym_q == LAST);
    load    = !code_valid_q || code_ready;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      len_q[idx_q] <= len_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      step_q       <= '0;
      code_q       <= '0;
      left_q       <= '0;
      code_valid_q <= 1'b0;
      code_sym_q   <= '0;
      code_len_q   <= '0;
      code_out_q   <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      incomplete_q <= 1'b0;
      for (int i = 0; i < NL; i++) begin
        bl_q[i] <= '0;
        nc_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (state_q == S_IDLE) begin
              for (int i = 0; i < NL; i++) begin
                bl_q[i] <= '0;
              end
              error_q      <= 1'b0;
              incomplete_q <= 1'b0;
              if (len_in != '0) begin
                bl_q[len_in] <= BW'(1);
              end
            end else if (len_in != '0) begin
              bl_q[len_in] <= bl_q[len_in] + BW'(1);
            end
            if (idx_q == LAST) begin
              state_q <= S_CALC;
              idx_q   <= '0;
              step_q  <= LEN_W'(1);
              code_q  <= '0;
              left_q  <= LW'(1);
            end else begin
              state_q <= S_LOAD;
              idx_q   <= idx_q + SYM_W'(1);
            end
          end
        end
        S_CALC: begin
          nc_q[step_q] <= code_d;
          code_q       <= code_d;
          left_q       <= left_d;
          if (neg_d) begin
            error_q <= 1'b1;
          end
          if (step_q == MAXL) begin
            if (error_q || neg_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              incomplete_q <= left_d > 0;
              state_q      <= S_EMIT;
            end
          end else begin
            step_q <= step_q + LEN_W'(1);
          end
        end
        S_EMIT: begin
          if (last_hs) begin
            code_valid_q <= 1'b0;
            state_q      <= S_FIN;
            done_q       <= 1'b1;
          end else if (load) begin
            // Each presented symbol is consumed before the run ends, so
            // bumping next_code at presentation matches bump-on-handshake.
            code_valid_q <= 1'b1;
            code_sym_q   <= idx_q;
            code_len_q   <= elen;
            code_out_q   <= ecode_d;
            if (elen != '0) begin
              nc_q[elen] <= eraw + MAX_LEN'(1);
            end
            idx_q <= idx_q + SYM_W'(1);
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clv_canon.sv
// Bench for clv_canon: 8-symbol pair (plain and bit-reversed) plus the
// default 288-symbol build, checked against a canonical-code model.
module tb_clv_canon;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       lv8;
  logic [2:0] lin8;
  logic       cr8;
  logic       lr_a, cv_a, done_a, err_a, inc_a;
  logic [2:0] sym_a, len_a;
  logic [3:0] code_a;
  logic       lr_b, cv_b, done_b, err_b, inc_b;
  logic [2:0] sym_b, len_b;
  logic [3:0] code_b;

  logic        lv9;
  logic [3:0]  lin9;
  logic        cr9;
  logic        lr9, cv9, done9, err9, inc9;
  logic [8:0]  sym9;
  logic [3:0]  len9;
  logic [14:0] code9;

  clv_canon #(.NUM_SYMBOLS(8), .MAX_LEN(4), .LEN_W(3), .SYM_W(3),
              .REVERSE(1'b0)) u_a (
    .clk(clk), .reset(reset), .len_valid(lv8), .len_in(lin8),
    .len_ready(lr_a), .code_valid(cv_a), .code_ready(cr8),
    .code_sym(sym_a), .code_len(len_a), .code_out(code_a),
    .done(done_a), .error(err_a), .incomplete(inc_a));

  clv_canon #(.NUM_SYMBOLS(8), .MAX_LEN(4), .LEN_W(3), .SYM_W(3),
              .REVERSE(1'b1)) u_b (
    .clk(clk), .reset(reset), .len_valid(lv8), .len_in(lin8),
    .len_ready(lr_b), .code_valid(cv_b), .code_ready(cr8),
    .code_sym(sym_b), .code_len(len_b), .code_out(code_b),
    .done(done_b), .error(err_b), .incomplete(inc_b));

  clv_canon u_c (
    .clk(clk), .reset(reset), .len_valid(lv9), .len_in(lin9),
    .len_ready(lr9), .code_valid(cv9), .code_ready(cr9),
    .code_sym(sym9), .code_len(len9), .code_out(code9),
    .done(done9), .error(err9), .incomplete(inc9));

  int n_chk = 0;
  int n_err = 0;
  int m_len [288];
  int m_code [288];
  bit exp_err, exp_inc;
  int t_last = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev(input int c, input int l);
    int r = 0;
    for (int i = 0; i < l; i++)
      if (((c >> (l - 1 - i)) & 1) != 0) r |= 1 << i;
    return r;
  endfunction

  // Canonical code = sum of shorter-length counts scaled up to this length,
  // plus rank among earlier symbols of the same length.
  task automatic model(input int n, input int maxl);
    int cnt [16];
    int sum, base, rank, l;
    sum = 0;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    for (int s = 0; s < n; s++)
      if (m_len[s] > 0) begin
        cnt[m_len[s]]++;
        sum += 1 << (maxl - m_len[s]);
      end
    exp_err = sum > (1 << maxl);
    exp_inc = !exp_err && sum < (1 << maxl);
    for (int s = 0; s < n; s++) begin
      l = m_len[s];
      m_code[s] = 0;
      if (l > 0) begin
        base = 0;
        rank = 0;
        for (int j = 1; j < l; j++) base += cnt[j] << (l - j);
        for (int j = 0; j < s; j++) if (m_len[j] == l) rank++;
        m_code[s] = base + rank;
      end
    end
  endtask

  task automatic load8(input int gap_pct);
    int n;
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        lv8 = 1'b0;
        lin8 = 3'($urandom);
      end
      @(negedge clk);
      lv8 = 1'b1;
      lin8 = 3'(m_len[i]);
      n = 0;
      while (!lr_a && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("load_timeout", 0, 1);
      t_last = cyc + 1;
    end
    @(negedge clk);
    lv8 = 1'b0;
  endtask

  task automatic mon8(input int rdy_pct);
    int k, n, hs_edge;
    bit seen, stall, fin;
    logic [10:0] held;
    k = 0; n = 0; hs_edge = -1;
    seen = 0; stall = 0; fin = 0; held = '0;
    while (!fin && n < 600) begin
      @(negedge clk);
      n++;
      if (stall) check("hold", {cv_a, sym_a, len_a, code_a}, held);
      if (cv_a && !seen) begin
        seen = 1;
        check("first_valid", cyc, t_last + 5);
      end
      if (done_a) begin
        check("done_err", err_a, exp_err);
        check("done_inc", inc_a, exp_inc);
        check("rev_err", err_b, exp_err);
        if (exp_err) check("done_time", cyc, t_last + 4);
        else check("done_time", cyc, hs_edge);
        @(negedge clk);
        check("done_pulse", done_a, 0);
        check("ready_back", lr_a, 1);
        fin = 1;
      end else begin
        cr8 = ($urandom_range(0, 99) < rdy_pct);
        if (cv_a && cr8) begin
          check("rvalid", cv_b, 1);
          if (k < 8) begin
            check("sym", sym_a, k);
            check("len", len_a, m_len[k]);
            check("code", code_a, m_code[k]);
            check("rcode", code_b, rev(m_code[k], m_len[k]));
          end
          k++;
          hs_edge = cyc + 1;
        end
        stall = cv_a && !cr8;
        held = {1'b1, sym_a, len_a, code_a};
      end
    end
    if (!fin) check("done_seen", 0, 1);
    check("hs_count", k, exp_err ? 0 : 8);
    check("valid_seen", seen, !exp_err);
    cr8 = 1'b0;
  endtask

  task automatic run8(input int gap_pct, input int rdy_pct);
    model(8, 4);
    fork
      load8(gap_pct);
      mon8(rdy_pct);
    join
  endtask

  task automatic set8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    m_len[0] = a0; m_len[1] = a1; m_len[2] = a2; m_len[3] = a3;
    m_len[4] = a4; m_len[5] = a5; m_len[6] = a6; m_len[7] = a7;
  endtask

  task automatic run288();
    int k, n;
    bit fin;
    for (int i = 0; i < 288; i++)
      m_len[i] = (i < 144) ? 8 : (i < 256) ? 9 : (i < 280) ? 7 : 8;
    model(288, 15);
    cr9 = 1'b1;
    for (int i = 0; i < 288; i++) begin
      @(negedge clk);
      lv9 = 1'b1;
      lin9 = 4'(m_len[i]);
      n = 0;
      while (!lr9 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("load9_timeout", 0, 1);
    end
    @(negedge clk);
    lv9 = 1'b0;
    k = 0; n = 0; fin = 0;
    while (!fin && n < 1200) begin
      if (cv9 && cr9) begin
        if (k < 288) begin
          check("sym9", sym9, k);
          check("code9", code9, m_code[k]);
        end
        if (k == 0) begin
          check("lit0", code9, 15'b00110000);
          check("lit0_len", len9, 8);
        end
        if (k == 144) begin
          check("lit144", code9, 15'b110010000);
          check("lit144_len", len9, 9);
        end
        if (k == 256) begin
          check("lit256", code9, 15'b0000000);
          check("lit256_len", len9, 7);
        end
        if (k == 280) begin
          check("lit280", code9, 15'b11000000);
          check("lit280_len", len9, 8);
        end
        k++;
      end
      if (done9) begin
        check("err9", err9, 0);
        check("inc9", inc9, 0);
        fin = 1;
      end
      @(negedge clk);
      n++;
    end
    if (!fin) check("done9_seen", 0, 1);
    check("hs9_count", k, 288);
    cr9 = 1'b0;
  endtask

  initial begin
    int n, t;
    reset = 1'b1;
    lv8 = 1'b0; lin8 = '0; cr8 = 1'b0;
    lv9 = 1'b0; lin9 = '0; cr9 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", lr_a, 0);
    check("rst_valid", cv_a, 0);
    check("rst_done", done_a, 0);
    check("rst_flags", {err_a, inc_a}, 0);
    check("rst_out", {sym_a, len_a, code_a}, 0);
    check("rst_out9", {cv9, sym9, code9}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", lr_a, 1);
    check("idle_ready9", lr9, 1);

    set8(3, 3, 3, 3, 3, 2, 4, 4);
    run8(0, 100);
    set8(1, 1, 1, 0, 0, 0, 0, 0);
    run8(0, 100);
    set8(1, 0, 0, 0, 0, 0, 0, 0);
    run8(0, 100);
    set8(0, 0, 0, 0, 0, 0, 0, 0);
    run8(10, 100);

    for (int r = 0; r < 4; r++) begin
      set8(3, 3, 3, 3, 3, 2, 4, 4);
      for (int i = 7; i > 0; i--) begin
        int j, tmp;
        j = $urandom_range(0, i);
        tmp = m_len[i]; m_len[i] = m_len[j]; m_len[j] = tmp;
      end
      run8(30, 60);
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) m_len[i] = $urandom_range(0, 4);
      run8(20, 70);
    end

    set8(3, 3, 3, 3, 3, 2, 4, 4);
    model(8, 4);
    cr8 = 1'b1;
    fork
      load8(0);
      begin
        n = 0;
        while (!(cv_a && sym_a == 3'd3) && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
    join
    if (n >= 100) check("emit3_timeout", 0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", cv_a, 0);
    check("mid_rst_ready", lr_a, 0);
    check("mid_rst_out", {done_a, sym_a, code_a}, 0);
    reset = 1'b0;
    cr8 = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", lr_a, 1);
    set8(2, 2, 2, 3, 3, 0, 0, 0);
    run8(0, 100);
    set8(3, 3, 3, 3, 3, 2, 4, 4);
    run8(0, 100);

    t = cyc;
    run288();
    check("run288_bound", (cyc - t) < 1500, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
